// File: rtl/axil4_pkg.sv
// ---------------------------------------------------------------------------
// axil4_pkg
// Shared definitions for the AXI-Lite line-memory slave:
//   axil4_state_e : controller states
//   RESP_OKAY / RESP_SLVERR : write-response codes
//   GRANT_RD / GRANT_WR     : encoding of the arbiter's last_grant flag
//   resp_code()             : maps an address-error flag to a response code
// ---------------------------------------------------------------------------
package axil4_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_ACC     = 3'd1,
      RD_RESP    = 3'd2,
      WR_COLLECT = 3'd3,
      WR_ACC     = 3'd4,
      WR_RESP    = 3'd5
   } axil4_state_e;

   localparam logic [31:0] RESP_OKAY   = 32'd0;
   localparam logic [31:0] RESP_SLVERR = 32'd2;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   function automatic logic [31:0] resp_code(input logic err);
      if (err) begin
         return RESP_SLVERR;
      end else begin
         return RESP_OKAY;
      end
   endfunction

endpackage

// File: rtl/axil4_rr_arb.sv
// ---------------------------------------------------------------------------
// axil4_rr_arb
// Two-requester round-robin arbiter. Bit 0 is the read side, bit 1 the write
// side. The last_grant flag only moves when both sides request in a cycle
// where upd_i is high, so an uncontested transaction leaves the priority
// untouched. After reset last_grant points at read, so write wins first.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req_i[1:0]: {write request, read request}
//   upd_i     : arbitration cycle qualifier (controller idle)
//   gnt_o[1:0]: one-hot grant when contended, otherwise mirrors req_i
// ---------------------------------------------------------------------------
module axil4_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic [1:0] gnt_o
);
   import axil4_pkg::*;

   logic last_grant_q;
   logic last_grant_d;

   // Grant and next priority from the current requests
   always_comb begin
      gnt_o        = 2'b00;
      last_grant_d = last_grant_q;
      if (req_i == 2'b11) begin
         if (last_grant_q == GRANT_RD) begin
            gnt_o = 2'b10;
         end else begin
            gnt_o = 2'b01;
         end
         if (upd_i) begin
            last_grant_d = gnt_o[1] ? GRANT_WR : GRANT_RD;
         end else begin
            last_grant_d = last_grant_q;
         end
      end else begin
         gnt_o = req_i;
      end
   end

   // Priority flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_RD;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/axil4_mem_slave.sv
// ---------------------------------------------------------------------------
// axil4_mem_slave
// AXI-Lite style slave in front of a single-port line array (one line per
// DATA_W/8 bytes). One transaction is in flight at a time; reads and writes
// contending in IDLE are served round-robin by axil4_rr_arb.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   readAddr_*  / readData_*     : read address / read data channels
//   writeAddr_* / writeData_*    : write address / write data (+strobes)
//   writeResp_*                  : write response (0 OKAY, 2 SLVERR)
//   mem_en/we/addr/wdata/bwe     : array request; mem_bwe is per-bit
//   mem_rdata                    : array data, valid one cycle after a read
// Build option:
//   AXIL4_ADDR_CHECK_EN : addresses with bits [31:ADDR_W] set are rejected
//                         (reads return zero, writes return SLVERR, and the
//                         array is not touched). Undefined: upper bits ignored.
// ---------------------------------------------------------------------------
module axil4_mem_slave #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         readAddr_addr,
   input  logic                readAddr_valid,
   output logic                readAddr_ready,
   output logic [DATA_W-1:0]   readData_data,
   output logic                readData_valid,
   input  logic                readData_ready,
   input  logic [31:0]         writeAddr_addr,
   input  logic                writeAddr_valid,
   output logic                writeAddr_ready,
   input  logic [DATA_W-1:0]   writeData_data,
   input  logic [DATA_W/8-1:0] writeData_strb,
   input  logic                writeData_valid,
   output logic                writeData_ready,
   output logic [31:0]         writeResp_msg,
   output logic                writeResp_valid,
   input  logic                writeResp_ready,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-5:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_bwe,
   input  logic [DATA_W-1:0]   mem_rdata
);
   import axil4_pkg::*;

   localparam int STRB_W = DATA_W / 8;
   localparam int LINE_W = ADDR_W - 4;

   axil4_state_e        state_q,  state_d;
   logic [LINE_W-1:0]   addr_q,   addr_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [STRB_W-1:0]   strb_q,   strb_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic [31:0]         bmsg_q,   bmsg_d;
   logic                got_aw_q, got_aw_d;
   logic                got_w_q,  got_w_d;
   logic                err_q,    err_d;
   logic                rvalid_q, rvalid_d;
   logic                bvalid_q, bvalid_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;

   logic                rd_req_s, wr_req_s, contend_s;
   logic [1:0]          gnt_s;
   logic                ar_rdy_s, aw_rdy_s, w_rdy_s;
   logic                ar_hs_s, aw_hs_s, w_hs_s;
   logic                wr_both_s, wr_err_s;
   logic                rd_addr_err_s, wr_addr_err_s;
   logic                unused_addr_bits_s;

`ifdef AXIL4_ADDR_CHECK_EN
   assign rd_addr_err_s = (readAddr_addr  >> ADDR_W) != 32'd0;
   assign wr_addr_err_s = (writeAddr_addr >> ADDR_W) != 32'd0;
`else
   assign rd_addr_err_s = 1'b0;
   assign wr_addr_err_s = 1'b0;
`endif

   // Byte offset and (without the check) the upper bits carry no meaning here.
   assign unused_addr_bits_s = ^{readAddr_addr[31:ADDR_W],  readAddr_addr[3:0],
                                 writeAddr_addr[31:ADDR_W], writeAddr_addr[3:0]};

   assign rd_req_s  = readAddr_valid;
   assign wr_req_s  = writeAddr_valid | writeData_valid;
   assign contend_s = rd_req_s & wr_req_s;

   axil4_rr_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i ({wr_req_s, rd_req_s}),
      .upd_i (state_q == IDLE),
      .gnt_o (gnt_s)
   );

   // Channel readies: all open in IDLE except the contention loser's
   always_comb begin
      ar_rdy_s = 1'b0;
      aw_rdy_s = 1'b0;
      w_rdy_s  = 1'b0;
      if (rst) begin
         ar_rdy_s = 1'b0;
         aw_rdy_s = 1'b0;
         w_rdy_s  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ar_rdy_s = ~(contend_s & gnt_s[1]);
               aw_rdy_s = ~(contend_s & gnt_s[0]);
               w_rdy_s  = ~(contend_s & gnt_s[0]);
            end
            WR_COLLECT: begin
               aw_rdy_s = ~got_aw_q;
               w_rdy_s  = ~got_w_q;
            end
            default: begin
               ar_rdy_s = 1'b0;
               aw_rdy_s = 1'b0;
               w_rdy_s  = 1'b0;
            end
         endcase
      end
   end

   assign readAddr_ready  = ar_rdy_s;
   assign writeAddr_ready = aw_rdy_s;
   assign writeData_ready = w_rdy_s;

   assign ar_hs_s   = readAddr_valid  & ar_rdy_s;
   assign aw_hs_s   = writeAddr_valid & aw_rdy_s;
   assign w_hs_s    = writeData_valid & w_rdy_s;
   assign wr_both_s = (got_aw_q | aw_hs_s) & (got_w_q | w_hs_s);
   assign wr_err_s  = aw_hs_s ? wr_addr_err_s : err_q;

   // Next state, channel captures and array request
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      rdata_d  = rdata_q;
      bmsg_d   = bmsg_q;
      got_aw_d = got_aw_q;
      got_w_d  = got_w_q;
      err_d    = err_q;
      rvalid_d = rvalid_q;
      bvalid_d = bvalid_q;
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;

      // Read and write-address handshakes are mutually exclusive by the readies.
      if (ar_hs_s) begin
         addr_d = readAddr_addr[ADDR_W-1:4];
         err_d  = rd_addr_err_s;
      end else if (aw_hs_s) begin
         addr_d   = writeAddr_addr[ADDR_W-1:4];
         err_d    = wr_addr_err_s;
         got_aw_d = 1'b1;
      end else begin
         addr_d = addr_q;
      end

      if (w_hs_s) begin
         wdata_d = writeData_data;
         strb_d  = writeData_strb;
         got_w_d = 1'b1;
      end else begin
         wdata_d = wdata_q;
      end

      case (state_q)
         IDLE: begin
            if (ar_hs_s) begin
               state_d  = RD_ACC;
               mem_en_d = ~rd_addr_err_s;
            end else if (wr_both_s) begin
               state_d  = WR_ACC;
               mem_en_d = ~wr_err_s;
               mem_we_d = ~wr_err_s;
            end else if (aw_hs_s | w_hs_s) begin
               state_d = WR_COLLECT;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ACC: begin
            state_d = RD_RESP;
         end
         RD_RESP: begin
            // First cycle here is when the array data is valid.
            if (!rvalid_q) begin
               rdata_d  = err_q ? {DATA_W{1'b0}} : mem_rdata;
               rvalid_d = 1'b1;
            end else if (readData_ready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d = RD_RESP;
            end
         end
         WR_COLLECT: begin
            if (wr_both_s) begin
               state_d  = WR_ACC;
               mem_en_d = ~wr_err_s;
               mem_we_d = ~wr_err_s;
            end else begin
               state_d = WR_COLLECT;
            end
         end
         WR_ACC: begin
            state_d  = WR_RESP;
            got_aw_d = 1'b0;
            got_w_d  = 1'b0;
         end
         WR_RESP: begin
            if (!bvalid_q) begin
               bvalid_d = 1'b1;
               bmsg_d   = resp_code(err_q);
            end else if (writeResp_ready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d = WR_RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= {LINE_W{1'b0}};
         wdata_q  <= {DATA_W{1'b0}};
         strb_q   <= {STRB_W{1'b0}};
         rdata_q  <= {DATA_W{1'b0}};
         bmsg_q   <= RESP_OKAY;
         got_aw_q <= 1'b0;
         got_w_q  <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         bvalid_q <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         rdata_q  <= rdata_d;
         bmsg_q   <= bmsg_d;
         got_aw_q <= got_aw_d;
         got_w_q  <= got_w_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
         bvalid_q <= bvalid_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
      end
   end

   // Gating with rst kills an array write already scheduled for this cycle.
   assign mem_en          = mem_en_q & ~rst;
   assign mem_we          = mem_we_q & ~rst;
   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign readData_valid  = rvalid_q & ~rst;
   assign readData_data   = rdata_q;
   assign writeResp_valid = bvalid_q & ~rst;
   assign writeResp_msg   = bmsg_q;

   for (genvar i = 0; i < STRB_W; i++) begin : g_bwe
      assign mem_bwe[i*8 +: 8] = {8{strb_q[i]}};
   end

endmodule

// File: tb/tb_axil4_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axil4_mem_slave
// Directed bench for axil4_mem_slave with a behavioural line array and
// scoreboard queues for read data and write responses.
// ---------------------------------------------------------------------------
module tb_axil4_mem_slave;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   readAddr_addr;
   logic          readAddr_valid;
   logic          readAddr_ready;
   logic [127:0]  readData_data;
   logic          readData_valid;
   logic          readData_ready;
   logic [31:0]   writeAddr_addr;
   logic          writeAddr_valid;
   logic          writeAddr_ready;
   logic [127:0]  writeData_data;
   logic [15:0]   writeData_strb;
   logic          writeData_valid;
   logic          writeData_ready;
   logic [31:0]   writeResp_msg;
   logic          writeResp_valid;
   logic          writeResp_ready;
   logic          mem_en;
   logic          mem_we;
   logic [11:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_bwe;
   logic [127:0]  mem_rdata;

   logic [127:0]  mem_arr [0:4095];
   logic          pre_en = 1'b0;
   logic [11:0]   pre_addr = 12'd0;
   logic [127:0]  pre_data = 128'd0;

   int            cyc;
   int            men_cnt;
   int            checks;
   int            failures;

   logic [127:0]  exp_rd_q [$];
   logic [31:0]   exp_wr_q [$];

   int            ch, cr, cw, cb, ch2, cr2, cw2, cb2, m0;
   bit            saw;
   logic [127:0]  held;

   axil4_mem_slave dut (
      .clk             (clk),
      .rst             (rst),
      .readAddr_addr   (readAddr_addr),
      .readAddr_valid  (readAddr_valid),
      .readAddr_ready  (readAddr_ready),
      .readData_data   (readData_data),
      .readData_valid  (readData_valid),
      .readData_ready  (readData_ready),
      .writeAddr_addr  (writeAddr_addr),
      .writeAddr_valid (writeAddr_valid),
      .writeAddr_ready (writeAddr_ready),
      .writeData_data  (writeData_data),
      .writeData_strb  (writeData_strb),
      .writeData_valid (writeData_valid),
      .writeData_ready (writeData_ready),
      .writeResp_msg   (writeResp_msg),
      .writeResp_valid (writeResp_valid),
      .writeResp_ready (writeResp_ready),
      .mem_en          (mem_en),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_bwe         (mem_bwe),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural line array: per-bit write enable, one-cycle read latency
   always @(posedge clk) begin
      if (pre_en) mem_arr[pre_addr] <= pre_data;
      if (mem_en && mem_we)
         mem_arr[mem_addr] <= (mem_arr[mem_addr] & ~mem_bwe) | (mem_wdata & mem_bwe);
      if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
      if (mem_en) men_cnt <= men_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [11:0] line, input logic [127:0] v);
      pre_addr = line;
      pre_data = v;
      pre_en   = 1'b1;
      @(posedge clk); #1;
      pre_en   = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output int c_hs);
      bit done = 0;
      c_hs = 0;
      readAddr_addr  = a;
      readAddr_valid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (readAddr_ready === 1'b1) begin
            done = 1;
            c_hs = cyc;
         end
      end
      @(posedge clk); #1;
      readAddr_valid = 1'b0;
      check("ar_handshake", {127'd0, done}, 128'd1);
   endtask

   task automatic write_txn(input logic [31:0] a, input logic [127:0] d,
                            input logic [15:0] s, input int gap, output int c_last);
      bit aw_done = 0;
      bit w_done  = 0;
      bit hs_aw;
      bit hs_w;
      int cnt;
      cnt    = gap;
      c_last = 0;
      writeAddr_addr  = a;
      writeData_data  = d;
      writeData_strb  = s;
      writeAddr_valid = 1'b1;
      writeData_valid = (gap == 0);
      for (int n = 0; n < 100 && !(aw_done && w_done); n++) begin
         @(negedge clk);
         hs_aw = (writeAddr_valid && writeAddr_ready);
         hs_w  = (writeData_valid && writeData_ready);
         if (hs_aw || hs_w) c_last = cyc;
         @(posedge clk); #1;
         if (hs_aw) begin aw_done = 1; writeAddr_valid = 1'b0; end
         if (hs_w)  begin w_done  = 1; writeData_valid = 1'b0; end
         if (!w_done && !writeData_valid) begin
            if (cnt > 0) cnt--;
            if (cnt == 0) writeData_valid = 1'b1;
         end
      end
      writeAddr_valid = 1'b0;
      writeData_valid = 1'b0;
      check("w_handshakes", {126'd0, aw_done, w_done}, 128'd3);
   endtask

   task automatic wait_r(input string tag, output int c_seen);
      bit seen = 0;
      logic [127:0] e;
      c_seen = 0;
      for (int n = 0; n < 64 && !seen; n++) begin
         @(negedge clk);
         if (readData_valid === 1'b1) begin
            seen   = 1;
            c_seen = cyc;
         end
      end
      check({tag, "_rvalid"}, {127'd0, seen}, 128'd1);
      check({tag, "_sb_rd_nonempty"}, {127'd0, exp_rd_q.size() != 0}, 128'd1);
      if (seen && exp_rd_q.size() != 0) begin
         e = exp_rd_q.pop_front();
         check({tag, "_rdata"}, readData_data, e);
      end
   endtask

   task automatic wait_b(input string tag, output int c_seen);
      bit seen = 0;
      logic [31:0] e;
      c_seen = 0;
      for (int n = 0; n < 64 && !seen; n++) begin
         @(negedge clk);
         if (writeResp_valid === 1'b1) begin
            seen   = 1;
            c_seen = cyc;
         end
      end
      check({tag, "_bvalid"}, {127'd0, seen}, 128'd1);
      check({tag, "_sb_wr_nonempty"}, {127'd0, exp_wr_q.size() != 0}, 128'd1);
      if (seen && exp_wr_q.size() != 0) begin
         e = exp_wr_q.pop_front();
         check({tag, "_msg"}, {96'd0, writeResp_msg}, {96'd0, e});
      end
   endtask

   initial begin
      rst             = 1'b1;
      readAddr_addr   = 32'd0;
      readAddr_valid  = 1'b0;
      readData_ready  = 1'b1;
      writeAddr_addr  = 32'd0;
      writeAddr_valid = 1'b0;
      writeData_data  = 128'd0;
      writeData_strb  = 16'd0;
      writeData_valid = 1'b0;
      writeResp_ready = 1'b1;
      checks          = 0;
      failures        = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_readies", {125'd0, readAddr_ready, writeAddr_ready, writeData_ready}, 128'd0);
      check("rst_valids",  {126'd0, readData_valid, writeResp_valid}, 128'd0);
      check("rst_mem",     {126'd0, mem_en, mem_we}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_readies", {125'd0, readAddr_ready, writeAddr_ready, writeData_ready}, 128'd7);

      // Single read with minimum latency
      preload(12'h010, 128'h0123456789ABCDEF_0123456789ABCDEF);
      exp_rd_q.push_back(128'h0123456789ABCDEF_0123456789ABCDEF);
      send_ar(32'h0000_0100, ch);
      wait_r("rd1", cr);
      check("rd1_latency", 128'(cr - ch), 128'd3);

      // Split write: data two cycles after address, low four bytes only
      preload(12'h020, 128'h11111111_22222222_33333333_44444444);
      exp_wr_q.push_back(32'd0);
      write_txn(32'h0000_0200, 128'h00000000_00000000_00000000_AABBCCDD, 16'h000F, 2, cw);
      wait_b("wr_split", cb);
      check("wr_split_latency", 128'(cb - cw), 128'd3);
      check("wr_split_line", mem_arr[12'h020], 128'h11111111_22222222_33333333_AABBCCDD);

      // Full-line write then read-back through the slave
      preload(12'h060, 128'd0);
      exp_wr_q.push_back(32'd0);
      write_txn(32'h0000_060C, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C, 16'hFFFF, 0, cw);
      wait_b("wr_full", cb);
      check("wr_full_latency", 128'(cb - cw), 128'd3);
      exp_rd_q.push_back(128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C);
      send_ar(32'h0000_0600, ch);
      wait_r("rd_back", cr);

      // Zero strobe writes nothing but still answers OKAY
      preload(12'h030, 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA);
      exp_wr_q.push_back(32'd0);
      write_txn(32'h0000_0300, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'h0000, 0, cw);
      wait_b("wr_strb0", cb);
      check("wr_strb0_line", mem_arr[12'h030], 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA);

      // First collision: write wins
      preload(12'h070, 128'h77777777_77777777_77777777_77777777);
      preload(12'h080, 128'd0);
      exp_wr_q.push_back(32'd0);
      exp_rd_q.push_back(128'h77777777_77777777_77777777_77777777);
      fork
         begin
            write_txn(32'h0000_0800, 128'h88888888_88888888_88888888_88888888, 16'hFFFF, 0, cw);
            wait_b("coll1_w", cb);
         end
         begin
            send_ar(32'h0000_0700, ch);
            wait_r("coll1_r", cr);
         end
      join
      check("coll1_write_first", {127'd0, cw < ch}, 128'd1);
      check("coll1_line", mem_arr[12'h080], 128'h88888888_88888888_88888888_88888888);

      // Second collision: read wins
      preload(12'h090, 128'd0);
      exp_wr_q.push_back(32'd0);
      exp_rd_q.push_back(128'h77777777_77777777_77777777_77777777);
      fork
         begin
            write_txn(32'h0000_0900, 128'h99999999_99999999_99999999_99999999, 16'hFFFF, 0, cw2);
            wait_b("coll2_w", cb2);
         end
         begin
            send_ar(32'h0000_0700, ch2);
            wait_r("coll2_r", cr2);
         end
      join
      check("coll2_read_first", {127'd0, ch2 < cw2}, 128'd1);
      check("coll2_line", mem_arr[12'h090], 128'h99999999_99999999_99999999_99999999);

      // Backpressure on read data, with a second read waiting
      preload(12'h050, 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3);
      preload(12'h051, 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3);
      readData_ready = 1'b0;
      exp_rd_q.push_back(128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3);
      send_ar(32'h0000_0500, ch);
      wait_r("bp_first", cr);
      held = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
      readAddr_addr  = 32'h0000_0510;
      readAddr_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid_held", {127'd0, readData_valid}, 128'd1);
         check("bp_data_stable", readData_data, held);
         check("bp_no_ar_ready", {127'd0, readAddr_ready}, 128'd0);
      end
      readData_ready = 1'b1;
      exp_rd_q.push_back(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3);
      send_ar(32'h0000_0510, ch);
      wait_r("bp_second", cr);
      check("bp_second_latency", 128'(cr - ch), 128'd3);

      // Upper address bits
      preload(12'h000, 128'd0);
      m0 = men_cnt;
`ifdef AXIL4_ADDR_CHECK_EN
      exp_wr_q.push_back(32'd2);
      write_txn(32'h0001_0000, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16'hFFFF, 0, cw);
      wait_b("hiaddr_w", cb);
      check("hiaddr_w_no_mem", 128'(men_cnt - m0), 128'd0);
      check("hiaddr_w_line0", mem_arr[12'h000], 128'd0);
      exp_rd_q.push_back(128'd0);
      send_ar(32'h0001_0100, ch);
      wait_r("hiaddr_r", cr);
      check("hiaddr_r_no_mem", 128'(men_cnt - m0), 128'd0);
`else
      exp_wr_q.push_back(32'd0);
      write_txn(32'h0001_0000, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16'hFFFF, 0, cw);
      wait_b("hiaddr_w", cb);
      check("hiaddr_w_one_mem", 128'(men_cnt - m0), 128'd1);
      check("hiaddr_w_line0", mem_arr[12'h000], 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
`endif

      // Reset while the array write is being issued
      preload(12'h040, 128'h40404040_40404040_40404040_40404040);
      write_txn(32'h0000_0400, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 16'hFFFF, 0, cw);
      check("rstmid_in_acc", {126'd0, mem_en, mem_we}, 128'd3);
      rst = 1'b1;
      m0  = men_cnt;
      @(negedge clk);
      check("rstmid_mem_off", {126'd0, mem_en, mem_we}, 128'd0);
      check("rstmid_readies", {125'd0, readAddr_ready, writeAddr_ready, writeData_ready}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_valids", {126'd0, readData_valid, writeResp_valid}, 128'd0);
      check("rstmid_idle", {125'd0, readAddr_ready, writeAddr_ready, writeData_ready}, 128'd7);
      saw = 0;
      repeat (8) begin
         @(negedge clk);
         if (writeResp_valid === 1'b1) saw = 1;
      end
      check("rstmid_no_resp", {127'd0, saw}, 128'd0);
      check("rstmid_no_mem", 128'(men_cnt - m0), 128'd0);
      check("rstmid_line", mem_arr[12'h040], 128'h40404040_40404040_40404040_40404040);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil4_mem_slave.md
AXIL4_MEM_SLAVE -- requirements
Module: axil4_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the byte-address bits decoded; upper address bits are ignored.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the line width in bits; STRB_W = DATA_W/8.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have ports readAddr_addr (in, 32), readAddr_valid (in, 1) and readAddr_ready (out, 1), forming the read-address channel.
REQ-006 SHALL have ports readData_data (out, DATA_W), readData_valid (out, 1) and readData_ready (in, 1), forming the read-data channel.
REQ-007 SHALL have ports writeAddr_addr (in, 32), writeAddr_valid (in, 1) and writeAddr_ready (out, 1), forming the write-address channel.
REQ-008 SHALL have ports writeData_data (in, DATA_W), writeData_strb (in, STRB_W), writeData_valid (in, 1) and writeData_ready (out, 1), forming the write-data channel.
REQ-009 SHALL have ports writeResp_msg (out, 32), writeResp_valid (out, 1) and writeResp_ready (in, 1), forming the write-response channel.
REQ-010 SHALL have the array port: mem_en (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W-4), mem_wdata (out, DATA_W), mem_bwe (out, DATA_W, per-bit write enable), and mem_rdata (in, DATA_W, valid exactly 1 cycle after mem_en with mem_we=0).

Function
REQ-011 SHALL complete a transfer on a channel only in a cycle where valid and ready are both 1.
REQ-012 SHALL implement states IDLE, RD_ACC, RD_RESP, WR_COLLECT, WR_ACC and WR_RESP.
REQ-013 SHALL, in IDLE, assert readAddr_ready, writeAddr_ready and writeData_ready; it SHALL deassert each of them in every other state, except WR_COLLECT, where only the still-missing write channel is ready.
REQ-014 SHALL, when only a read arrives, latch addr[ADDR_W-1:4] and go to RD_ACC; RD_ACC pulses mem_en=1 with mem_we=0, then the block goes to RD_RESP.
REQ-015 SHALL, in RD_RESP, capture mem_rdata into a holding register on entry and hold readData_valid=1 with stable data until readData_ready; it then returns to IDLE.
REQ-016 SHALL, when writeAddr and writeData are both accepted, go to WR_ACC; if only one of them is accepted, it SHALL go to WR_COLLECT and wait for the other.
REQ-017 SHALL, in WR_ACC, pulse mem_en=1 and mem_we=1 for 1 cycle; mem_bwe byte i is all-ones iff strb[i]=1, so strb=0 writes nothing.
REQ-018 SHALL, in WR_RESP, hold writeResp_valid=1 with writeResp_msg=0 (OKAY) until writeResp_ready; it then returns to IDLE.
REQ-019 SHALL, when a read and a write are both pending in IDLE, serve them round-robin using a 1-bit last_grant flag; after reset the write wins.
REQ-020 SHALL deassert all ready signals of the losing side in the arbitration cycle, so that the loser is not consumed.
REQ-021 SHALL take minimum latencies of 3 cycles from read-address handshake to readData_valid, and 3 cycles from the final write-channel handshake to writeResp_valid.
REQ-022 SHALL keep at most one transaction outstanding; there is no reordering.

Reset
REQ-023 SHALL, while rst=1, set the state to IDLE, last_grant to read (so the write wins next), drive every valid and mem_en/mem_we to 0, and zero the holding registers.
REQ-024 SHALL, when rst is asserted mid-transaction, abandon that transaction with no response and no array write after rst; all readies are 0 while rst=1.

Configuration
REQ-025 SHALL, with AXIL4_ADDR_CHECK_EN defined, treat any address with bits [31:ADDR_W] nonzero as an error: such a read returns all-zero data with no array access, and such a write returns writeResp_msg=2 (SLVERR) with no array access.
REQ-026 SHALL, without AXIL4_ADDR_CHECK_EN, ignore the upper address bits and always return OKAY.

Structure
REQ-027 SHALL place the state enum and the response codes (RESP_OKAY=0, RESP_SLVERR=2) in shared package axil4_pkg.
REQ-028 SHALL contain one sub-module, axil4_rr_arb, a 2-request round-robin arbiter holding last_grant.

Verification
REQ-029 Single read: array line 0x10 preloaded with 0x0123..CDEF, read addr 0x100 -> readData_valid on cycle +3 with that data.
REQ-030 Split write: writeAddr 0x200 accepted, writeData 2 cycles later with strb=0x000F and data 0xAABBCCDD -> only bytes 0-3 of line 0x20 change, then msg=0.
REQ-031 Contention: read and write valid in the same IDLE cycle, twice -> write first, then read; on the second collision, read first.
REQ-032 Backpressure: readData_ready held 0 for 5 cycles -> valid and data stable, and no new readAddr_ready.
REQ-033 Reset mid-WR_ACC: assert rst -> no writeResp, state IDLE, all valids 0 next cycle.
REQ-034 With AXIL4_ADDR_CHECK_EN, a write to 0x0001_0000 -> writeResp_msg=2 and mem_en never asserted.
